serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: DIFF = A - B - BIN, one bit per cycle, LSB first,

---
 rtl/serial_subtractor.sv | 171 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, LSB first,
// one full-subtractor step per clock with a registered borrow.
// Operands arrive on a valid/ready handshake and the result leaves on another.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | shifting one bit per cycle through the full-subtractor cell
// S_DONE | result held on the outputs until the consumer takes it
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             borrow_q, borrow_d;
    logic             msb_a_q, msb_a_d;
    logic             msb_b_q, msb_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shadow copies of the accepted operands, kept only for the self-check below.
    logic [WIDTH-1:0] a_chk_q, a_chk_d;
    logic [WIDTH-1:0] b_chk_q, b_chk_d;
    logic             bin_chk_q, bin_chk_d;

    logic             a0, b0;
    logic             diff_bit;
    logic             borrow_next;
    logic [WIDTH:0]   chk_full;

    // Full-subtractor cell acting on the current LSBs and the running borrow.
    always_comb begin
        a0          = a_sh_q[0];
        b0          = b_sh_q[0];
        diff_bit    = a0 ^ b0 ^ borrow_q;
        borrow_next = (~a0 & b0) | (~a0 & borrow_q) | (b0 & borrow_q);
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        d_sh_d    = d_sh_q;
        borrow_d  = borrow_q;
        msb_a_d   = msb_a_q;
        msb_b_d   = msb_b_q;
        cnt_d     = cnt_q;
        a_chk_d   = a_chk_q;
        b_chk_d   = b_chk_q;
        bin_chk_d = bin_chk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_diff  = '0;
        out_bout  = 1'b0;
        out_ovf   = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d    = in_a;
                    b_sh_d    = in_b;
                    borrow_d  = in_bin;
                    msb_a_d   = in_a[WIDTH-1];
                    msb_b_d   = in_b[WIDTH-1];
                    cnt_d     = '0;
                    a_chk_d   = in_a;
                    b_chk_d   = in_b;
                    bin_chk_d = in_bin;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                d_sh_d   = {diff_bit, d_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                borrow_d = borrow_next;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Outputs are driven straight from registers that do not move in
                // this state, so they stay stable under backpressure.
                out_valid = 1'b1;
                out_diff  = d_sh_q;
                out_bout  = borrow_q;
                out_ovf   = (msb_a_q ^ msb_b_q) & (d_sh_q[WIDTH-1] ^ msb_a_q);
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            d_sh_q    <= '0;
            borrow_q  <= 1'b0;
            msb_a_q   <= 1'b0;
            msb_b_q   <= 1'b0;
            cnt_q     <= '0;
            a_chk_q   <= '0;
            b_chk_q   <= '0;
            bin_chk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            d_sh_q    <= d_sh_d;
            borrow_q  <= borrow_d;
            msb_a_q   <= msb_a_d;
            msb_b_q   <= msb_b_d;
            cnt_q     <= cnt_d;
            a_chk_q   <= a_chk_d;
            b_chk_q   <= b_chk_d;
            bin_chk_q <= bin_chk_d;
        end
    end

    // Reference result: {not-borrow, diff} of the captured operands.
    always_comb begin
        chk_full = {1'b1, a_chk_q} - {1'b0, b_chk_q} - {{WIDTH{1'b0}}, bin_chk_q};
    end

    // Embedded consistency checks, evaluated outside reset.
    always @(posedge clk) begin
        if (rst_n) begin
            a_hs_excl: assert (!(in_ready && out_valid))
                else $error("in_ready and out_valid both high");
            if (state_q == S_DONE) begin
                a_result: assert ({~out_bout, out_diff} == chk_full)
                    else $error("serial result disagrees with A-B-BIN");
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid_8, in_ready_8, in_bin_8, out_valid_8, out_ready_8;
    logic        out_bout_8, out_ovf_8;
    logic [7:0]  in_a_8, in_b_8, out_diff_8;

    logic        in_valid_16, in_ready_16, in_bin_16, out_valid_16, out_ready_16;
    logic        out_bout_16, out_ovf_16;
    logic [15:0] in_a_16, in_b_16, out_diff_16;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [17:0] q8[$];
    logic [17:0] q16[$];
    time         t8[$];
    time         t16[$];
    logic        held8 = 1'b0;
    logic        held16 = 1'b0;
    bit          stop_rand;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_a(in_a_8), .in_b(in_b_8), .in_bin(in_bin_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_diff(out_diff_8), .out_bout(out_bout_8), .out_ovf(out_ovf_8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_16), .in_ready(in_ready_16),
        .in_a(in_a_16), .in_b(in_b_16), .in_bin(in_bin_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .out_diff(out_diff_16), .out_bout(out_bout_16), .out_ovf(out_ovf_16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {bout, ovf, diff} for a w-bit subtraction.
    function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic bin);
        logic [16:0] full;
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        if (w == 8) begin
            d    = {8'd0, full[7:0]};
            bout = full[8];
        end else begin
            d    = full[15:0];
            bout = full[16];
        end
        ovf = (a[w-1] ^ b[w-1]) & (d[w-1] ^ a[w-1]);
        return {bout, ovf, d};
    endfunction

    // Monitor, WIDTH=8: push on accept, compare while valid, pop on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            t8.delete();
            held8 = 1'b0;
        end else begin
            if (in_valid_8 && in_ready_8) begin
                q8.push_back(model(8, {8'd0, in_a_8}, {8'd0, in_b_8}, in_bin_8));
                t8.push_back($time);
            end
            if (out_valid_8) begin
                check_eq("busy8", 32'(in_ready_8), 32'd0);
                if (!held8) begin
                    // negedge before accept edge E to first negedge after edge E+WIDTH
                    if (t8.size() == 0) check_eq("lat8_orphan", 32'd1, 32'd0);
                    else check_eq("lat8", 32'(($time - t8.pop_front()) / 10), 32'd9);
                end
                if (q8.size() == 0) begin
                    check_eq("res8_orphan", 32'd1, 32'd0);
                end else begin
                    check_eq("res8", 32'({out_bout_8, out_ovf_8, 8'd0, out_diff_8}), 32'(q8[0]));
                    if (out_ready_8) void'(q8.pop_front());
                end
            end
            held8 = out_valid_8 && !out_ready_8;
        end
    end

    // Monitor, WIDTH=16.
    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            t16.delete();
            held16 = 1'b0;
        end else begin
            if (in_valid_16 && in_ready_16) begin
                q16.push_back(model(16, in_a_16, in_b_16, in_bin_16));
                t16.push_back($time);
            end
            if (out_valid_16) begin
                check_eq("busy16", 32'(in_ready_16), 32'd0);
                if (!held16) begin
                    if (t16.size() == 0) check_eq("lat16_orphan", 32'd1, 32'd0);
                    else check_eq("lat16", 32'(($time - t16.pop_front()) / 10), 32'd17);
                end
                if (q16.size() == 0) begin
                    check_eq("res16_orphan", 32'd1, 32'd0);
                end else begin
                    check_eq("res16", 32'({out_bout_16, out_ovf_16, out_diff_16}), 32'(q16[0]));
                    if (out_ready_16) void'(q16.pop_front());
                end
            end
            held16 = out_valid_16 && !out_ready_16;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int k;
        in_a_8 = a; in_b_8 = b; in_bin_8 = bin; in_valid_8 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(in_ready_8 && rst_n) && k < 400);
        if (!(in_ready_8 && rst_n)) check_eq("accept8_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        in_a_8 = 8'($urandom); in_b_8 = 8'($urandom); in_bin_8 = 1'($urandom);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int k;
        in_a_16 = a; in_b_16 = b; in_bin_16 = bin; in_valid_16 = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(in_ready_16 && rst_n) && k < 400);
        if (!(in_ready_16 && rst_n)) check_eq("accept16_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid_16 = 1'b0;
        in_a_16 = 16'($urandom); in_b_16 = 16'($urandom); in_bin_16 = 1'($urandom);
    endtask

    task automatic drain8();
        int k = 0;
        while (q8.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain8", 32'(q8.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain16();
        int k = 0;
        while (q16.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain16", 32'(q16.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle8(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready_8),  32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_8), 32'd0);
        check_eq({tag, "_diff"},      32'(out_diff_8),  32'd0);
        check_eq({tag, "_bout"},      32'(out_bout_8),  32'd0);
        check_eq({tag, "_ovf"},       32'(out_ovf_8),   32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        in_valid_8 = 1'b0;  in_a_8 = '0;  in_b_8 = '0;  in_bin_8 = 1'b0;  out_ready_8 = 1'b1;
        in_valid_16 = 1'b0; in_a_16 = '0; in_b_16 = '0; in_bin_16 = 1'b0; out_ready_16 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle8("rst8");
        check_eq("rst16_in_ready",  32'(in_ready_16),  32'd1);
        check_eq("rst16_out_valid", 32'(out_valid_16), 32'd0);
        check_eq("rst16_diff",      32'(out_diff_16),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        send8(8'h05, 8'h03, 1'b0);
        drain8();
        send8(8'h00, 8'h01, 1'b0);
        send8(8'h00, 8'h00, 1'b1);
        drain8();
        send8(8'h80, 8'h01, 1'b0);
        send8(8'h7F, 8'hFF, 1'b0);
        drain8();
        send16(16'h8000, 16'h0001, 1'b0);
        send16(16'h0000, 16'hFFFF, 1'b1);
        drain16();

        // Backpressure: hold the result for five cycles, then release it.
        out_ready_8 = 1'b0;
        send8(8'hC3, 8'h3C, 1'b1);
        k = 0;
        while (!out_valid_8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("bp_reach_done", 32'(out_valid_8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid_held", 32'(out_valid_8), 32'd1);
        end
        @(posedge clk); #1;
        out_ready_8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("bp_release_in_ready",  32'(in_ready_8),  32'd1);
        check_eq("bp_release_out_valid", 32'(out_valid_8), 32'd0);
        @(posedge clk); #1;

        // Reset after three bits of RUN discards the operation.
        send8(8'h3C, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle8("midrun_rst");
        @(posedge clk); #1;
        send8(8'h5A, 8'hA5, 1'b0);
        drain8();

        // Random back-to-back traffic on both widths with random backpressure.
        stop_rand = 1'b0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 1000; i++) begin
                            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                            send8(8'($urandom), 8'($urandom), 1'($urandom));
                        end
                    end
                    begin
                        for (int j = 0; j < 1000; j++) begin
                            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                            send16(16'($urandom), 16'($urandom), 1'($urandom));
                        end
                    end
                join
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk); #1;
                    out_ready_8  = ($urandom_range(0, 3) != 0);
                    out_ready_16 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready_8 = 1'b1;
        out_ready_16 = 1'b1;
        drain8();
        drain16();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
